// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM timebase.
//   DEF_CNT_W / DEF_PSC_W : default counter and prescaler widths
//   DIR_UP / DIR_DOWN     : encoding of the up_down control input
//   cnt_t                 : counter-width value type at the default width
package pwm_pkg;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_PSC_W = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef logic [DEF_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk down to a counting tick.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   en            : counting enable; low freezes psc_cnt
//   clr           : synchronous clear of psc_cnt (beats en)
//   prescale_act  : tick every prescale_act+1 enabled cycles
//   tick          : combinational; high in the cycle the counter must advance
//   psc_cnt       : internal prescale count, exported for observation
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_W = DEF_PSC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] prescale_act,
    output logic             tick,
    output logic [PSC_W-1:0] psc_cnt
);

    logic match;

    // Equality (not >=) is deliberate: if prescale drops below psc_cnt the
    // count runs up to its maximum, rolls over to 0 and then ticks normally.
    assign match = (psc_cnt == prescale_act);
    assign tick  = en && !clr && match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt <= '0;
        end else if (clr) begin
            psc_cnt <= '0;
        end else if (en) begin
            if (match) begin
                psc_cnt <= '0;
            end else begin
                psc_cnt <= psc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_counter.sv
// pwm_counter: free-running timebase feeding the PWM output generator.
// Optional feature macro: PWM_CNT_SHADOW_EN -- when defined, period and
// prescale are buffered in shadow registers that load only at a wrap, on
// cnt_clr, or while cnt_en is low, so mid-period writes apply next period.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   cnt_en     : counting enable; low freezes counter and prescaler
//   cnt_clr    : synchronous clear (0 in up mode, period_act in down mode)
//   up_down    : 1 = up, 0 = down
//   period     : terminal count; counter spans 0..period
//   prescale   : counter advances every prescale+1 clk cycles
//   count_val  : registered count
//   cnt_tick   : one-cycle pulse when the counter is advanced by a tick
//   wrap       : one-cycle pulse when the counter wraps
//   period_act : period currently in force
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PSC_W = DEF_PSC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    input  logic             up_down,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic [CNT_W-1:0] count_val,
    output logic             cnt_tick,
    output logic             wrap,
    output logic [CNT_W-1:0] period_act
);

    logic [PSC_W-1:0] prescale_act;
    logic [CNT_W-1:0] period_load;
    logic [PSC_W-1:0] psc_cnt;
    logic             tick;
    logic             wrap_cond;
    logic             count_up;

    assign count_up = (up_down == DIR_UP);

    // Wrap decision against the period currently in force. Using >= in up
    // mode and > in down mode lets a shrunk period recover on the next tick.
    always_comb begin
        wrap_cond = 1'b0;
        if (count_up) begin
            wrap_cond = (count_val >= period_act);
        end else begin
            wrap_cond = (count_val == '0) || (count_val > period_act);
        end
    end

`ifdef PWM_CNT_SHADOW_EN
    logic             capture;
    logic [CNT_W-1:0] period_act_reg;
    logic [PSC_W-1:0] prescale_act_reg;

    assign capture = cnt_clr || !cnt_en || (tick && wrap_cond);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_act_reg   <= '0;
            prescale_act_reg <= '0;
        end else if (capture) begin
            period_act_reg   <= period;
            prescale_act_reg <= prescale;
        end
    end

    assign period_act   = period_act_reg;
    assign prescale_act = prescale_act_reg;
    // A down-mode reload coincides with a shadow capture, so the new period
    // is loaded directly and the next period starts from its own top value.
    assign period_load  = period;
`else
    assign period_act   = period;
    assign prescale_act = prescale;
    assign period_load  = period;
`endif

    pwm_prescaler #(
        .PSC_W(PSC_W)
    ) u_prescaler (
        .clk          (clk),
        .rst          (rst),
        .en           (cnt_en),
        .clr          (cnt_clr),
        .prescale_act (prescale_act),
        .tick         (tick),
        .psc_cnt      (psc_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_val <= '0;
            cnt_tick  <= 1'b0;
            wrap      <= 1'b0;
        end else if (cnt_clr) begin
            count_val <= count_up ? '0 : period_load;
            cnt_tick  <= 1'b0;
            wrap      <= 1'b0;
        end else if (tick) begin
            cnt_tick <= 1'b1;
            wrap     <= wrap_cond;
            if (wrap_cond) begin
                count_val <= count_up ? '0 : period_load;
            end else if (count_up) begin
                count_val <= count_val + 1'b1;
            end else begin
                count_val <= count_val - 1'b1;
            end
        end else begin
            cnt_tick <= 1'b0;
            wrap     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_counter.sv
// Scoreboard bench for pwm_counter: the stimulus process pushes the expected
// registered outputs for each cycle it drives; a monitor pops and compares
// one entry per clock, and a second monitor checks the asynchronous reset.
module tb_pwm_counter;

    logic        clk;
    logic        rst;
    logic        cnt_en;
    logic        cnt_clr;
    logic        up_down;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic [15:0] count_val;
    logic        cnt_tick;
    logic        wrap;
    logic [15:0] period_act;

    typedef struct {
        logic [15:0] cv;
        logic        w;
        logic        t;
        bit          chk_t;
        logic [15:0] pa;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t async_q[$];
    int   checks = 0;
    int   errors = 0;

    pwm_counter dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .up_down    (up_down),
        .period     (period),
        .prescale   (prescale),
        .count_val  (count_val),
        .cnt_tick   (cnt_tick),
        .wrap       (wrap),
        .period_act (period_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        bit ok;
        ok = (count_val == e.cv) && (wrap == e.w) && (!e.chk_t || cnt_tick == e.t);
`ifndef PWM_CNT_SHADOW_EN
        ok = ok && (period_act == e.pa);
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got cv=%0d wrap=%0b tick=%0b pa=%0d, want cv=%0d wrap=%0b tick=%0b(chk=%0b) pa=%0d",
                     e.name, count_val, wrap, cnt_tick, period_act, e.cv, e.w, e.t, e.chk_t, e.pa);
        end else begin
            $display("ok   %s: cv=%0d wrap=%0b tick=%0b", e.name, count_val, wrap, cnt_tick);
        end
    endtask

    // Clocked monitor: one expectation per rising edge while entries exist.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) compare(exp_q.pop_front());
        end
    end

    // Asynchronous reset monitor: checks outputs shortly after rst rises.
    initial begin
        forever begin
            @(posedge rst);
            #1;
            if (async_q.size() > 0) compare(async_q.pop_front());
        end
    end

    task automatic step(input bit r, input bit en, input bit clr, input bit ud,
                        input int per, input int psc,
                        input int cv, input bit w, input bit t, input bit chk_t,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst      = r;
        cnt_en   = en;
        cnt_clr  = clr;
        up_down  = ud;
        period   = 16'(per);
        prescale = 8'(psc);
        e.cv = 16'(cv); e.w = w; e.t = t; e.chk_t = chk_t;
        e.pa = 16'(per); e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t ae;
        int   drain;
        rst = 1'b1; cnt_en = 1'b0; cnt_clr = 1'b0; up_down = 1'b1;
        period = '0; prescale = '0;

        // Reset state, counting requested but held in reset.
        step(1, 1, 0, 1, 4, 0, 0, 0, 0, 1, "reset0");
        step(1, 1, 0, 1, 4, 0, 0, 0, 0, 1, "reset1");

        // 1: up, prescale 0, period 4 -> 0,1,2,3,4,0(wrap),1
        step(0, 1, 1, 1, 4, 0, 0, 0, 0, 1, "t1_clr");
        for (int i = 1; i <= 6; i++)
            step(0, 1, 0, 1, 4, 0, i % 5, (i == 5), 1, 1, "t1_up");

        // 2: down, prescale 2, period 3 -> 3,2,1,0,3 held 3 clk each
        step(0, 1, 1, 0, 3, 2, 3, 0, 0, 1, "t2_clr");
        for (int i = 1; i <= 15; i++)
            step(0, 1, 0, 0, 3, 2, 3 - ((i / 3) % 4), (i == 12), (i % 3 == 0), 1, "t2_down");

        // 3: enable/clear, prescale 2, period 20
        step(0, 1, 1, 1, 20, 2, 0, 0, 0, 1, "t3_clr");
        for (int i = 1; i <= 21; i++)
            step(0, 1, 0, 1, 20, 2, i / 3, 0, (i % 3 == 0), 1, "t3_up");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 1, 20, 2, 7, 0, 0, 1, "t3_hold");
        step(0, 0, 1, 1, 20, 2, 0, 0, 0, 1, "t3_clr_dis");
        for (int i = 1; i <= 3; i++)
            step(0, 1, 0, 1, 20, 2, i / 3, 0, (i == 3), 1, "t3_reen");

        // 4: period shrink from 10 to 5 at count 8
        step(0, 1, 1, 1, 10, 0, 0, 0, 0, 1, "t4_clr");
        for (int i = 1; i <= 8; i++)
            step(0, 1, 0, 1, 10, 0, i, 0, 1, 1, "t4_up");
`ifdef PWM_CNT_SHADOW_EN
        step(0, 1, 0, 1, 5, 0, 9, 0, 1, 1, "t4_shadow");
        step(0, 1, 0, 1, 5, 0, 10, 0, 1, 1, "t4_shadow");
`endif
        step(0, 1, 0, 1, 5, 0, 0, 1, 1, 1, "t4_shrink_wrap");
        for (int i = 1; i <= 6; i++)
            step(0, 1, 0, 1, 5, 0, i % 6, (i == 6), 1, 1, "t4_new_period");

        // 5: asynchronous reset at count 9
        step(0, 1, 1, 1, 20, 0, 0, 0, 0, 1, "t5_clr");
        for (int i = 1; i <= 9; i++)
            step(0, 1, 0, 1, 20, 0, i, 0, 1, 1, "t5_up");
        @(posedge clk);
        #2;
        ae.cv = '0; ae.w = 1'b0; ae.t = 1'b0; ae.chk_t = 1'b1; ae.pa = 16'd20;
        ae.name = "t5_async_rst";
        async_q.push_back(ae);
        rst = 1'b1;
        step(1, 1, 0, 1, 20, 0, 0, 0, 0, 1, "t5_in_rst");
        step(0, 1, 0, 1, 20, 0, 1, 0, 1, 1, "t5_restart");
        step(0, 1, 0, 1, 20, 0, 2, 0, 1, 1, "t5_restart");

        // 6: period 0, prescale 1, both directions -> 0, wrap every 2 clk
        step(0, 1, 1, 1, 0, 1, 0, 0, 0, 1, "t6_clr_up");
        for (int i = 1; i <= 4; i++)
            step(0, 1, 0, 1, 0, 1, 0, (i % 2 == 0), 0, 0, "t6_up");
        step(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, "t6_clr_dn");
        for (int i = 1; i <= 4; i++)
            step(0, 1, 0, 0, 0, 1, 0, (i % 2 == 0), 0, 0, "t6_dn");

        drain = 0;
        while ((exp_q.size() > 0 || async_q.size() > 0) && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0 || async_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size() + async_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
